// File: rtl/game_fsm.sv
// Penalty-shootout controller: START -> SHOOTER/KEEPER rounds with a frame-counted result hold -> WINNER/LOOSER.
// Optional macro SUDDEN_DEATH_EN: a tie after regulation plays extra rounds instead of losing.
module game_fsm #(
  parameter int ROUNDS      = 5,
  parameter int HOLD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       mode_sel,
  input  logic       frame_tick,
  input  logic       shot_done,
  input  logic       shot_scored,
  output logic [2:0] game_state,
  output logic       game_mode,
  output logic [3:0] round_counter,
  output logic [3:0] score_player,
  output logic [3:0] score_opp,
  output logic       is_scored
);

  typedef enum logic [2:0] {
    ST_START   = 3'd0,
    ST_KEEPER  = 3'd1,
    ST_SHOOTER = 3'd2,
    ST_WINNER  = 3'd3,
    ST_LOOSER  = 3'd4
  } state_t;

  localparam int              CW        = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_FRAMES - 1);
  localparam logic [3:0]      ROUNDS_L  = 4'(ROUNDS);

  state_t        state_reg, state_next;
  logic          mode_reg, mode_next;
  logic [3:0]    round_reg, round_next;
  logic [3:0]    sp_reg, sp_next;
  logic [3:0]    so_reg, so_next;
  logic          scored_reg, scored_next;
  logic          hold_reg, hold_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          hold_end;
  logic [3:0]    round_inc;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic inc);
    return (inc && (v != 4'hF)) ? v + 4'd1 : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_START;
      mode_reg   <= 1'b1;
      round_reg  <= 4'd0;
      sp_reg     <= 4'd0;
      so_reg     <= 4'd0;
      scored_reg <= 1'b0;
      hold_reg   <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      mode_reg   <= mode_next;
      round_reg  <= round_next;
      sp_reg     <= sp_next;
      so_reg     <= so_next;
      scored_reg <= scored_next;
      hold_reg   <= hold_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign hold_end  = hold_reg && (cnt_reg == HOLD_LAST);
  assign round_inc = sat_inc(round_reg, 1'b1);

  always_comb begin
    state_next  = state_reg;
    mode_next   = mode_reg;
    round_next  = round_reg;
    sp_next     = sp_reg;
    so_next     = so_reg;
    scored_next = scored_reg;
    hold_next   = hold_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      ST_START: begin
        if (btn_start) begin
          state_next  = ST_SHOOTER;
          mode_next   = mode_sel;
          round_next  = 4'd0;
          sp_next     = 4'd0;
          so_next     = 4'd0;
          scored_next = 1'b0;
          hold_next   = 1'b0;
          cnt_next    = '0;
        end
      end
      ST_SHOOTER, ST_KEEPER: begin
        // While holding, kicks are ignored; the hold-end cycle also drops any kick.
        if (hold_end) begin
          scored_next = 1'b0;
          hold_next   = 1'b0;
          cnt_next    = '0;
          if (state_reg == ST_SHOOTER) begin
            state_next = ST_KEEPER;
          end else begin
            round_next = round_inc;
            if (round_inc < ROUNDS_L)     state_next = ST_SHOOTER;
            else if (sp_reg > so_reg)     state_next = ST_WINNER;
            else if (sp_reg < so_reg)     state_next = ST_LOOSER;
            else begin
`ifdef SUDDEN_DEATH_EN
              state_next = ST_SHOOTER;
`else
              state_next = ST_LOOSER;
`endif
            end
          end
        end else if (hold_reg) begin
          if (frame_tick) cnt_next = cnt_reg + 1'b1;
        end else if (shot_done) begin
          if (state_reg == ST_SHOOTER) sp_next = sat_inc(sp_reg, shot_scored);
          else                         so_next = sat_inc(so_reg, shot_scored);
          scored_next = shot_scored;
          hold_next   = 1'b1;
          cnt_next    = '0;
        end
      end
      ST_WINNER, ST_LOOSER: begin
        if (btn_start) state_next = ST_START;
      end
      default: state_next = ST_START;
    endcase
  end

  assign game_state    = state_reg;
  assign game_mode     = mode_reg;
  assign round_counter = round_reg;
  assign score_player  = sp_reg;
  assign score_opp     = so_reg;
  assign is_scored     = scored_reg;

endmodule

// File: tb/tb_game_fsm.sv
// Scoreboard bench for game_fsm: stimulus pushes expected outputs, a monitor pops and compares on each falling edge.
module tb_game_fsm;

  localparam logic [2:0] S_START   = 3'd0;
  localparam logic [2:0] S_KEEPER  = 3'd1;
  localparam logic [2:0] S_SHOOTER = 3'd2;
  localparam logic [2:0] S_WINNER  = 3'd3;
  localparam logic [2:0] S_LOOSER  = 3'd4;
  localparam int         HOLD      = 60;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_start, mode_sel, frame_tick, shot_done, shot_scored;
  logic [2:0] game_state;
  logic       game_mode;
  logic [3:0] round_counter, score_player, score_opp;
  logic       is_scored;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic       md;
    logic [3:0] rc;
    logic [3:0] sp;
    logic [3:0] so;
    logic       sc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic       md_m;
  logic [3:0] rc_m, sp_m, so_m;

  game_fsm dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .mode_sel(mode_sel),
    .frame_tick(frame_tick), .shot_done(shot_done), .shot_scored(shot_scored),
    .game_state(game_state), .game_mode(game_mode), .round_counter(round_counter),
    .score_player(score_player), .score_opp(score_opp), .is_scored(is_scored)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation consumed per falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (game_state !== e.st || game_mode !== e.md || round_counter !== e.rc ||
            score_player !== e.sp || score_opp !== e.so || is_scored !== e.sc) begin
          failures++;
          $display("FAIL %s: got st=%0d md=%0d rc=%0d sp=%0d so=%0d sc=%0d, want st=%0d md=%0d rc=%0d sp=%0d so=%0d sc=%0d",
                   e.name, game_state, game_mode, round_counter, score_player, score_opp, is_scored,
                   e.st, e.md, e.rc, e.sp, e.so, e.sc);
        end else begin
          $display("[%0t] %s ok: st=%0d md=%0d rc=%0d sp=%0d so=%0d sc=%0d",
                   $time, e.name, game_state, game_mode, round_counter, score_player, score_opp, is_scored);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic expect_out(input string name, input logic [2:0] st, input logic sc);
    exp_t e;
    e.name = name; e.st = st; e.md = md_m; e.rc = rc_m; e.sp = sp_m; e.so = so_m; e.sc = sc;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input logic bs, input logic sd, input logic ss, input logic ft);
    btn_start = bs; shot_done = sd; shot_scored = ss; frame_tick = ft;
    @(posedge clk);
    #1;
    btn_start = 1'b0; shot_done = 1'b0; shot_scored = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic run_hold(input int n);
    for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic play_round(input logic p, input logic o, input logic [2:0] end_st);
    pulse(1'b0, 1'b1, p, 1'b0);
    sp_m = sp_m + 4'(p);
    expect_out("shooter_kick", S_SHOOTER, p);
    run_hold(HOLD);
    expect_out("shooter_hold_end", S_KEEPER, 1'b0);
    pulse(1'b0, 1'b1, o, 1'b0);
    so_m = so_m + 4'(o);
    expect_out("keeper_kick", S_KEEPER, o);
    run_hold(HOLD);
    rc_m = rc_m + 4'd1;
    expect_out("keeper_hold_end", end_st, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; btn_start = 1'b0; mode_sel = 1'b0;
    frame_tick = 1'b0; shot_done = 1'b0; shot_scored = 1'b0;
    md_m = 1'b1; rc_m = 4'd0; sp_m = 4'd0; so_m = 4'd0;
    @(negedge clk); #1;
    expect_out("reset_values", S_START, 1'b0);
    rst_n = 1'b1;
    expect_out("idle_start", S_START, 1'b0);

    // Game 1: SOLO, regulation win 4-2
    mode_sel = 1'b0;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    md_m = 1'b0;
    expect_out("start_solo", S_SHOOTER, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("btn_in_shooter_ignored", S_SHOOTER, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("scored_without_done_ignored", S_SHOOTER, 1'b0);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    sp_m = 4'd1;
    expect_out("scored_kick", S_SHOOTER, 1'b1);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    expect_out("kick_during_hold_ignored", S_SHOOTER, 1'b1);
    run_hold(HOLD);
    expect_out("hold_end_to_keeper", S_KEEPER, 1'b0);
    pulse(1'b0, 1'b1, 1'b1, 1'b1);
    so_m = 4'd1;
    expect_out("collision_kick_accepted", S_KEEPER, 1'b1);
    run_hold(HOLD);
    rc_m = 4'd1;
    expect_out("round1_end", S_SHOOTER, 1'b0);
    play_round(1'b1, 1'b0, S_SHOOTER);
    play_round(1'b1, 1'b1, S_SHOOTER);
    play_round(1'b1, 1'b0, S_SHOOTER);
    play_round(1'b0, 1'b0, S_WINNER);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    expect_out("winner_frozen", S_WINNER, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("winner_restart", S_START, 1'b0);

    // Game 2: MULTI, 3-3 after regulation
    mode_sel = 1'b1;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    md_m = 1'b1; rc_m = 4'd0; sp_m = 4'd0; so_m = 4'd0;
    expect_out("start_multi", S_SHOOTER, 1'b0);
    play_round(1'b1, 1'b1, S_SHOOTER);
    play_round(1'b1, 1'b1, S_SHOOTER);
    play_round(1'b1, 1'b0, S_SHOOTER);
    play_round(1'b0, 1'b1, S_SHOOTER);
`ifdef SUDDEN_DEATH_EN
    play_round(1'b0, 1'b0, S_SHOOTER);
    play_round(1'b1, 1'b0, S_WINNER);
`else
    play_round(1'b0, 1'b0, S_LOOSER);
`endif
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("tie_game_restart", S_START, 1'b0);

    // Game 3: reset asserted mid-hold in KEEPER
    mode_sel = 1'b0;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    md_m = 1'b0; rc_m = 4'd0; sp_m = 4'd0; so_m = 4'd0;
    expect_out("start_game3", S_SHOOTER, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("missed_kick", S_SHOOTER, 1'b0);
    run_hold(HOLD);
    expect_out("to_keeper_g3", S_KEEPER, 1'b0);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    so_m = 4'd1;
    expect_out("keeper_kick_g3", S_KEEPER, 1'b1);
    run_hold(10);
    expect_out("mid_hold", S_KEEPER, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    md_m = 1'b1; rc_m = 4'd0; sp_m = 4'd0; so_m = 4'd0;
    expect_out("async_reset", S_START, 1'b0);
    rst_n = 1'b1;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("after_reset_release", S_START, 1'b0);

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
